md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit for the EX stage of the five-stage MIPS pipeline, sitting beside the ALU and fed by the same forwarded SrcA/WriteData operands. It runs MULT/MULTU/DIV/DIVU as multi-cycle operations, holds the architectural HI/LO registers, and exposes `busy` so the hazard unit can stall later MD instructions in ID. MFHI/MFLO read `hi`/`lo` combinationally into the EX result mux.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for MULT/MULTU (and MADD/MADDU); must be ≥ 1.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for DIV/DIVU; must be ≥ 1.
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: issue the operation in `md_op` this cycle. Asserted by EX-stage decode for one cycle per instruction.
- `md_op` input 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU.
- `a` input 32: rs operand, already forwarded.
- `b` input 32: rt operand, already forwarded.
- `busy` output 1: a multi-cycle operation is in flight.
- `hi` output 32: committed HI register.
- `lo` output 32: committed LO register.

## Operation
- States: IDLE, RUN. A down-counter of width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)) runs in RUN.
- IDLE + `start` + op 000–011 (or 110/111 when enabled):
  - capture result into shadow registers `hi_n`/`lo_n`;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE + `start` + MTHI/MTLO: `hi` (or `lo`) ← `a` on that edge. No RUN, `busy` stays 0.
- RUN: decrement every cycle. When the counter reaches 1, commit `hi` ← `hi_n`, `lo` ← `lo_n` and return to IDLE on the same edge.
- `start` while in RUN is ignored entirely, including MTHI/MTLO. The hazard unit must stall on `busy | start`.
- Arithmetic:
  - MULT: signed 32×32 → 64, `hi` = [63:32], `lo` = [31:0]. MULTU: unsigned.
  - DIV: signed, quotient truncated toward zero into `lo`, remainder with the sign of the dividend into `hi`. DIVU: unsigned.
  - 0x80000000 / 0xFFFFFFFF (signed): `lo` = 0x80000000, `hi` = 0.
  - Division by zero (`b` = 0, DIV or DIVU): the op still runs DIV_CYCLES with `busy` high, but `hi`/`lo` keep their old values at commit.
- `hi`/`lo` show only committed values. While `busy` is high they hold the pre-operation values.
- Reset (any state, including mid-RUN): state IDLE, counter 0, `busy` 0, `hi` 0, `lo` 0, shadow registers 0. The in-flight op is discarded.

## Timing
- `start` sampled at edge T: `busy` = 1 from just after T through edge T+N, where N = MULT_CYCLES or DIV_CYCLES.
- `hi`/`lo` update at edge T+N; `busy` falls at that same edge.
- A new `start` is accepted at edge T+N+1 at the earliest. Back-to-back issue period is N+1 cycles.
- MTHI/MTLO: `hi`/`lo` update at edge T. Visible to MFHI/MFLO in EX the next cycle.
- `reset` and `start` together: reset wins and the op is not captured.
- `busy` is a registered output; `hi`/`lo` are registered.

## Configuration
- `MD_MADD_EN` defined: op 110 (MADD) and 111 (MADDU) are supported, taking MULT_CYCLES.
  - Result is {`hi`,`lo`} + product (signed or unsigned) mod 2^64.
  - The accumulator base is the {`hi`,`lo`} value committed at the `start` edge.
- `MD_MADD_EN` undefined: ops 110/111 are treated as no-ops. `start` with them leaves state, `busy`, `hi` and `lo` unchanged.

## Test plan
- MULT `a`=0xFFFFFFFE (−2), `b`=3 → `busy` high 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV `a`=0xFFFFFFF9 (−7), `b`=2 → `busy` 10 cycles, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/2 → `lo`=3, `hi`=1.
- MTHI `a`=0x1234 → `hi`=0x1234 next cycle, `busy` never asserted. Then DIV by 0 → `busy` 10 cycles, `hi` still 0x1234, `lo` unchanged.
- MULT started; at cycle 3 of RUN assert MTLO `a`=0x55 together with a second MULT → both ignored. After commit, only the first product is present and `busy` falls at exactly T+5.
- DIV started; `reset` asserted at cycle 4 → next edge `busy`=0, `hi`=`lo`=0, and no late commit occurs.
- With `MD_MADD_EN`: `hi`=0, `lo`=0xFFFFFFFF, MADDU 1×1 → `hi`=1, `lo`=0. Without it: same stimulus → `busy` stays 0, `hi`/`lo` unchanged.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS multiply/divide unit that holds the HI/LO registers; results commit after MULT_CYCLES/DIV_CYCLES.
// Define MD_MADD_EN to enable MADD/MADDU (ops 110/111). Without it those ops are ignored.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   hi_n_q, hi_n_d, lo_n_q, lo_n_d;

  logic [63:0] a_sx, b_sx, prod_s, prod_u, mul_res;
  logic        div_signed, a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, ua, ub_safe, uq, ur, quo, rem;

  // The low 64 bits of the product of sign-extended operands equal the signed product.
  assign a_sx    = {{32{a[31]}}, a};
  assign b_sx    = {{32{b[31]}}, b};
  assign prod_s  = a_sx * b_sx;
  assign prod_u  = {32'b0, a} * {32'b0, b};
  assign mul_res = md_op[0] ? prod_u : prod_s;

  // Signed division works on magnitudes, so 0x80000000 / -1 yields 0x80000000 without overflow.
  assign div_signed = ~md_op[0];
  assign a_neg      = div_signed & a[31];
  assign b_neg      = div_signed & b[31];
  assign a_mag      = a_neg ? (32'd0 - a) : a;
  assign b_mag      = b_neg ? (32'd0 - b) : b;
  assign b_zero     = (b == 32'd0);
  assign ua         = a_mag;
  assign ub_safe    = b_zero ? 32'd1 : b_mag;
  assign uq         = ua / ub_safe;
  assign ur         = ua % ub_safe;
  assign quo        = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem        = a_neg ? (32'd0 - ur) : ur;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            3'b000, 3'b001: begin
              {hi_n_d, lo_n_d} = mul_res;
              cnt_d            = CW'(MULT_CYCLES);
              state_d          = RUN;
            end
            3'b010, 3'b011: begin
              // A zero divisor commits the current HI/LO, i.e. leaves them unchanged.
              hi_n_d  = b_zero ? hi_q : rem;
              lo_n_d  = b_zero ? lo_q : quo;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            3'b100: hi_d = a;
            3'b101: lo_d = a;
            default: begin
`ifdef MD_MADD_EN
              {hi_n_d, lo_n_d} = {hi_q, lo_q} + mul_res;
              cnt_d            = CW'(MULT_CYCLES);
              state_d          = RUN;
`endif
            end
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          hi_d    = hi_n_q;
          lo_d    = lo_n_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n_q  <= '0;
      lo_n_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed cases plus random ops against a 64-bit arithmetic reference model.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] nh, output logic [31:0] nl, output int n);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    nh = exp_hi;
    nl = exp_lo;
    n  = 0;
    case (op)
      3'd0: begin p = sx * sy; nh = p[63:32]; nl = p[31:0]; n = MC; end
      3'd1: begin p = {32'b0, x} * {32'b0, y}; nh = p[63:32]; nl = p[31:0]; n = MC; end
      3'd2: begin
        if (y != 0) begin q = sx / sy; r = sx % sy; nl = q[31:0]; nh = r[31:0]; end
        n = DC;
      end
      3'd3: begin
        if (y != 0) begin nl = x / y; nh = x % y; end
        n = DC;
      end
      3'd4: nh = x;
      3'd5: nl = x;
      default: begin
`ifdef MD_MADD_EN
        if (op == 3'd6) p = sx * sy;
        else            p = {32'b0, x} * {32'b0, y};
        p  = {exp_hi, exp_lo} + p;
        nh = p[63:32];
        nl = p[31:0];
        n  = MC;
`endif
      end
    endcase
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit inject, input string tag);
    logic [31:0] nh, nl;
    int          n;
    model(op, x, y, nh, nl, n);
    @(negedge clk);
    start = 1'b1; md_op = op; a = x; b = y;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk({tag, " busy"}, {63'b0, busy}, 64'd1);
      chk({tag, " hi hold"}, {32'b0, hi}, {32'b0, exp_hi});
      chk({tag, " lo hold"}, {32'b0, lo}, {32'b0, exp_lo});
      if (inject) begin
        start = 1'($urandom_range(0, 1));
        md_op = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start  = 1'b0;
    exp_hi = nh;
    exp_lo = nl;
    chk({tag, " busy done"}, {63'b0, busy}, 64'd0);
    chk({tag, " hi"}, {32'b0, hi}, {32'b0, exp_hi});
    chk({tag, " lo"}, {32'b0, lo}, {32'b0, exp_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; md_op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", {63'b0, busy}, 64'd0);
    chk("reset hi", {32'b0, hi}, 64'd0);
    chk("reset lo", {32'b0, lo}, 64'd0);
    reset = 1'b0;

    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult");
    chk("mult hi const", {32'b0, hi}, 64'hFFFF_FFFF);
    chk("mult lo const", {32'b0, lo}, 64'hFFFF_FFFA);
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, "multu");
    chk("multu hi const", {32'b0, hi}, 64'h2);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
    chk("div lo const", {32'b0, lo}, 64'hFFFF_FFFD);
    chk("div hi const", {32'b0, hi}, 64'hFFFF_FFFF);
    do_op(3'd3, 32'd7, 32'd2, 1'b0, "divu");
    chk("divu lo const", {32'b0, lo}, 64'd3);
    chk("divu hi const", {32'b0, hi}, 64'd1);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div ovf");
    chk("div ovf lo const", {32'b0, lo}, 64'h8000_0000);
    do_op(3'd4, 32'h1234, 32'd0, 1'b0, "mthi");
    chk("mthi const", {32'b0, hi}, 64'h1234);
    do_op(3'd2, 32'd5, 32'd0, 1'b0, "div0");
    chk("div0 hi const", {32'b0, hi}, 64'h1234);
    do_op(3'd0, 32'd7, 32'd9, 1'b1, "mult inject");

    do_op(3'd4, 32'd0, 32'd0, 1'b0, "mthi0");
    do_op(3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, "mtlo");
    do_op(3'd7, 32'd1, 32'd1, 1'b0, "maddu");
`ifdef MD_MADD_EN
    chk("maddu hi const", {32'b0, hi}, 64'd1);
    chk("maddu lo const", {32'b0, lo}, 64'd0);
`else
    chk("maddu off hi const", {32'b0, hi}, 64'd0);
    chk("maddu off lo const", {32'b0, lo}, 64'hFFFF_FFFF);
`endif

    // Reset in the middle of a division discards it entirely.
    @(negedge clk);
    start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun busy", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    chk("midrun reset busy", {63'b0, busy}, 64'd0);
    chk("midrun reset hi", {32'b0, hi}, 64'd0);
    chk("midrun reset lo", {32'b0, lo}, 64'd0);
    for (int k = 0; k < DC + 2; k++) begin
      @(negedge clk);
      chk("no late commit busy", {63'b0, busy}, 64'd0);
      chk("no late commit hi", {32'b0, hi}, 64'd0);
      chk("no late commit lo", {32'b0, lo}, 64'd0);
    end

    // Reset beats a simultaneous start.
    do_op(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0, "mthi pre");
    @(negedge clk);
    reset = 1'b1; start = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    exp_hi = '0; exp_lo = '0;
    chk("rst+start busy", {63'b0, busy}, 64'd0);
    chk("rst+start hi", {32'b0, hi}, 64'd0);
    @(negedge clk);
    chk("rst+start busy later", {63'b0, busy}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), bit'($urandom_range(0, 1)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
